// File: rtl/systolic_feeder_if.sv
// Handshake and array-side bundle for systolic_feeder.
// slave is the feeder's view; master is the upstream source plus array sink.
interface systolic_feeder_if #(
    parameter int unsigned ARRAY_SIZE = 2,
    parameter int unsigned DATA_WIDTH = 4
);
    localparam int unsigned VW = ARRAY_SIZE * DATA_WIDTH;

    // weight row channel
    logic          w_valid;
    logic          w_ready;
    logic [VW-1:0] w_data;

    // activation vector channel
    logic          a_valid;
    logic          a_ready;
    logic [VW-1:0] a_data;
    logic          a_last;

    // array-facing outputs and status
    logic          load;
    logic [VW-1:0] weights;
    logic [VW-1:0] activations;
    logic          busy;
    logic          done;

    modport slave (
        input  w_valid, w_data, a_valid, a_data, a_last,
        output w_ready, a_ready, load, weights, activations, busy, done
    );

    modport master (
        output w_valid, w_data, a_valid, a_data, a_last,
        input  w_ready, a_ready, load, weights, activations, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Feeder for the systolic array: preloads ARRAY_SIZE weight rows, then streams
// activation vectors through a per-lane diagonal skew line, flushes zeros
// after the last vector and pulses done.
module systolic_feeder #(
    parameter int unsigned ARRAY_SIZE   = 2,
    parameter int unsigned DATA_WIDTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 2 * ARRAY_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    systolic_feeder_if.slave  bus
);
    localparam int unsigned VW     = ARRAY_SIZE * DATA_WIDTH;
    localparam int unsigned ROW_W  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int unsigned FCNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ARRAY_SIZE - 1);
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

    typedef enum logic [1:0] {
        LOAD_W,
        STREAM,
        FLUSH
    } state_t;

    state_t              state_q;
    logic [ROW_W-1:0]    row_cnt_q;
    logic [FCNT_W-1:0]   flush_cnt_q;
    logic                load_q;
    logic [VW-1:0]       weights_q;
    logic                w_ready_q;
    logic                a_ready_q;
    logic                busy_q;
    logic                done_q;

    logic                w_xfer;
    logic                a_xfer;
    logic [VW-1:0]       inj_d;

    // Readies are registered and only ever high in their own state, so the
    // transfer qualifiers need no extra state decode.
    assign w_xfer = bus.w_valid & w_ready_q;
    assign a_xfer = bus.a_valid & a_ready_q;

    // Vector entering the skew line: accepted data, otherwise a zero bubble.
    always_comb begin
        inj_d = '0;
        if (a_xfer) begin
            inj_d = bus.a_data;
        end
    end

    // Control FSM with registered handshake, load and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOAD_W;
            row_cnt_q   <= '0;
            flush_cnt_q <= '0;
            load_q      <= 1'b0;
            weights_q   <= '0;
            w_ready_q   <= 1'b1;
            a_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            load_q <= w_xfer;
            done_q <= 1'b0;
            if (w_xfer) begin
                weights_q <= bus.w_data;
            end

            case (state_q)
                LOAD_W: begin
                    if (w_xfer) begin
                        if (row_cnt_q == ROW_LAST) begin
                            row_cnt_q <= '0;
                            state_q   <= STREAM;
                            w_ready_q <= 1'b0;
                            a_ready_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end

                STREAM: begin
                    if (a_xfer && bus.a_last) begin
                        a_ready_q <= 1'b0;
                        if (FLUSH_CYCLES == 0) begin
                            state_q   <= LOAD_W;
                            w_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q     <= FLUSH;
                            flush_cnt_q <= FCNT_INIT;
                        end
                    end
                end

                FLUSH: begin
                    if (flush_cnt_q == FCNT_ONE) begin
                        flush_cnt_q <= '0;
                        state_q     <= LOAD_W;
                        w_ready_q   <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q   <= LOAD_W;
                    row_cnt_q <= '0;
                    w_ready_q <= 1'b1;
                    a_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Skew line: lane i is an (i+1)-deep shift register; the oldest element
    // sits in the top slot and drives the lane output.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic [(i+1)*DATA_WIDTH-1:0] line_q;
        logic [DATA_WIDTH-1:0]       lane_in;

        assign lane_in = inj_d[i*DATA_WIDTH +: DATA_WIDTH];

        if (i == 0) begin : g_first
            // Single-stage lane: register the injected element.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    line_q <= '0;
                end else begin
                    line_q <= lane_in;
                end
            end
        end else begin : g_rest
            // Multi-stage lane: shift toward the top slot every cycle.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    line_q <= '0;
                end else begin
                    line_q <= {line_q[i*DATA_WIDTH-1:0], lane_in};
                end
            end
        end

        assign bus.activations[i*DATA_WIDTH +: DATA_WIDTH] =
            line_q[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH];
    end

    assign bus.w_ready = w_ready_q;
    assign bus.a_ready = a_ready_q;
    assign bus.load    = load_q;
    assign bus.weights = weights_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: the driver tracks the expected phase
// and queues expected loads, skewed activations and done cycles; a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_systolic_feeder;
    localparam int A = 2;
    localparam int D = 4;
    localparam int W = A * D;
    localparam int F = 2 * A;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    systolic_feeder_if #(.ARRAY_SIZE(A), .DATA_WIDTH(D)) bus ();

    systolic_feeder #(
        .ARRAY_SIZE  (A),
        .DATA_WIDTH  (D),
        .FLUSH_CYCLES(F)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef enum {P_LOAD, P_STREAM, P_FLUSH} phase_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    phase_t      ph    = P_LOAD;
    int          rows  = 0;

    logic [W-1:0] hist[$];     // vectors injected into the skew line, this batch
    logic [W-1:0] w_exp[$];    // expected weights per load pulse
    logic [W-1:0] act_exp[$];  // expected activations per busy cycle
    int           done_exp[$]; // expected cycle numbers of done pulses

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Array-facing skewed output: lane i shows the vector injected i edges ago.
    function automatic logic [W-1:0] skew_of();
        logic [W-1:0] r = '0;
        for (int i = 0; i < A; i++) begin
            int idx = hist.size() - 1 - i;
            if (idx >= 0) begin
                logic [W-1:0] v = hist[idx];
                r[i*D +: D] = v[i*D +: D];
            end
        end
        return r;
    endfunction

    // Monitor: compares every cycle against whatever the scoreboard queued.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.load) begin
                if (w_exp.size() == 0) fail_now("load_extra", "load high with nothing expected");
                else chk("weights", bus.weights, w_exp.pop_front());
            end
            if (bus.busy) begin
                if (act_exp.size() == 0) fail_now("busy_extra", "busy high with nothing expected");
                else chk("activations", bus.activations, act_exp.pop_front());
            end else begin
                chk("act_idle", bus.activations, '0);
            end
            if (bus.done) begin
                if (done_exp.size() == 0) fail_now("done_extra", "done pulse not expected");
                else chk("done_cycle", cyc, done_exp.pop_front());
            end
            if (done_exp.size() != 0 && cyc > done_exp[0]) begin
                fail_now("done_missing", "expected done pulse did not occur");
                void'(done_exp.pop_front());
            end
        end
    end

    task automatic check_ready();
        case (ph)
            P_LOAD:   begin chk("w_ready_load",   bus.w_ready, 1); chk("a_ready_load",   bus.a_ready, 0); end
            P_STREAM: begin chk("w_ready_stream", bus.w_ready, 0); chk("a_ready_stream", bus.a_ready, 1); end
            default:  begin chk("w_ready_flush",  bus.w_ready, 0); chk("a_ready_flush",  bus.a_ready, 0); end
        endcase
    endtask

    // One cycle in the weight phase; activation inputs carry junk.
    task automatic send_w(input bit v, input logic [W-1:0] d);
        @(negedge clk);
        check_ready();
        bus.w_valid = v;
        bus.w_data  = d;
        bus.a_valid = 1'b1;
        bus.a_data  = W'($urandom);
        bus.a_last  = 1'($urandom);
        if (v) begin
            w_exp.push_back(d);
            rows++;
            if (rows == A) begin
                rows = 0;
                ph   = P_STREAM;
                hist.delete();
                act_exp.push_back(skew_of());
            end
        end
    endtask

    // One cycle in the stream phase; w_valid is held high to show it is ignored.
    task automatic send_a(input bit v, input logic [W-1:0] d, input bit last);
        @(negedge clk);
        check_ready();
        bus.w_valid = 1'b1;
        bus.w_data  = W'($urandom);
        bus.a_valid = v;
        bus.a_data  = d;
        bus.a_last  = last;
        hist.push_back(v ? d : '0);
        act_exp.push_back(skew_of());
        if (v && last) begin
            ph = P_FLUSH;
            done_exp.push_back(cyc + 1 + F);
        end
    endtask

    // Flush cycles: zeros enter the line; a_valid stays high on the first one.
    task automatic do_flush();
        for (int j = 1; j <= F; j++) begin
            @(negedge clk);
            check_ready();
            bus.a_valid = (j == 1) ? 1'b1 : 1'($urandom);
            bus.a_data  = W'($urandom);
            bus.a_last  = 1'($urandom);
            bus.w_valid = 1'b0;
            hist.push_back('0);
            if (j < F) act_exp.push_back(skew_of());
        end
        ph = P_LOAD;
    endtask

    task automatic rand_batch();
        int n;
        for (int r = 0; r < A; r++) begin
            while ($urandom_range(0, 2) == 0) send_w(1'b0, W'($urandom));
            send_w(1'b1, W'($urandom));
        end
        n = $urandom_range(1, 6);
        for (int v = 0; v < n; v++) begin
            while ($urandom_range(0, 3) == 0) send_a(1'b0, W'($urandom), 1'($urandom));
            send_a(1'b1, W'($urandom), v == n - 1);
        end
        do_flush();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.a_last  = 1'b0;

        // Reset values
        #12;
        chk("rst_load", bus.load, 0);
        chk("rst_weights", bus.weights, 0);
        chk("rst_act", bus.activations, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_w_ready", bus.w_ready, 1);
        chk("rst_a_ready", bus.a_ready, 0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Back-to-back weights, then a two-vector skewed batch
        send_w(1'b1, 8'h43);
        send_w(1'b1, 8'h21);
        send_a(1'b1, 8'h21, 1'b0);
        send_a(1'b1, 8'h43, 1'b1);
        do_flush();

        // Bubble between vectors
        send_w(1'b1, 8'h43);
        send_w(1'b1, 8'h21);
        send_a(1'b1, 8'h21, 1'b0);
        send_a(1'b0, 8'hff, 1'b1);
        send_a(1'b1, 8'h43, 1'b1);
        do_flush();

        // Gappy weights; weights must hold through the gap; single-vector batch
        send_w(1'b1, 8'h43);
        send_w(1'b0, 8'h99);
        @(posedge clk); #1;
        chk("gap_weights", bus.weights, 8'h43);
        chk("gap_load", bus.load, 0);
        send_w(1'b1, 8'h21);
        send_a(1'b1, 8'h5a, 1'b1);
        do_flush();

        // Reset mid-stream aborts at once
        send_w(1'b1, 8'h43);
        send_w(1'b1, 8'h21);
        send_a(1'b1, 8'h21, 1'b0);
        @(posedge clk); #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("abort_act", bus.activations, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_load", bus.load, 0);
        chk("abort_weights", bus.weights, 0);
        chk("abort_w_ready", bus.w_ready, 1);
        chk("abort_a_ready", bus.a_ready, 0);
        w_exp.delete();
        act_exp.delete();
        done_exp.delete();
        hist.delete();
        ph   = P_LOAD;
        rows = 0;
        bus.w_valid = 1'b0;
        bus.a_valid = 1'b0;
        @(negedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        // After the abort two fresh rows are needed before streaming
        send_w(1'b1, 8'h76);
        send_w(1'b0, 8'h00);
        send_w(1'b1, 8'h54);
        send_a(1'b1, 8'h32, 1'b0);
        send_a(1'b1, 8'h10, 1'b1);
        do_flush();

        // Randomized batches
        for (int b = 0; b < 25; b++) rand_batch();

        repeat (3) @(negedge clk);
        chk("w_queue_empty", w_exp.size(), 0);
        chk("act_queue_empty", act_exp.size(), 0);
        chk("done_queue_empty", done_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream feeder for the `systolic` array. It accepts weight rows and unskewed activation vectors over valid/ready handshakes, drives the array's `load`/`weights` preload sequence, and applies the diagonal (per-lane) skew to the activations that the array requires. After the last activation vector it flushes zeros and signals completion. This replaces hand-sequenced stimulus in front of the array.

## Interface
- `ARRAY_SIZE`, default 2: array dimension; number of lanes and number of weight rows per preload.
- `DATA_WIDTH`, default 4: bits per weight/activation element.
- `FLUSH_CYCLES`, default 2*ARRAY_SIZE: number of zero-feed cycles after the last activation. Must be ≥ ARRAY_SIZE-1.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `w_valid` in 1: weight row valid.
- `w_ready` out 1: feeder accepts a weight row.
- `w_data` in ARRAY_SIZE*DATA_WIDTH: weight row; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `a_valid` in 1: activation vector valid.
- `a_ready` out 1: feeder accepts an activation vector.
- `a_data` in ARRAY_SIZE*DATA_WIDTH: unskewed activation vector, one element per lane.
- `a_last` in 1: marks the final vector of a batch; qualified by the handshake.
- `load` out 1: to array `load`.
- `weights` out ARRAY_SIZE*DATA_WIDTH: to array `weights`.
- `activations` out ARRAY_SIZE*DATA_WIDTH: skewed, to array `activations`.
- `busy` out 1: high in STREAM and FLUSH.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Handshake:** a transfer occurs on a rising edge where valid && ready.
- **FSM states:** LOAD_W, STREAM, FLUSH. Reset state is LOAD_W.
- **LOAD_W:**
  - `w_ready`=1, `a_ready`=0.
  - A row counter (width clog2(ARRAY_SIZE), min 1) counts accepted rows.
  - Each accepted row is registered onto `weights`, with `load`=1 for exactly the following cycle.
  - In cycles with no transfer, `load`=0 and `weights` holds its value.
  - Acceptance of row ARRAY_SIZE-1 clears the counter and moves the FSM to STREAM.
- **STREAM:**
  - `a_ready`=1, `w_ready`=0, `busy`=1.
  - The skew line advances every cycle.
  - The injected vector is `a_data` on a transfer, otherwise all zeros (bubble).
  - Accepted `a_last` moves the FSM to FLUSH.
- **Skew:**
  - Lane i of `activations` equals lane i of the injected vector from i cycles earlier, registered.
  - Lane 0 therefore has one register stage and lane i has i+1.
  - The skew line is shift-only; no arithmetic and no width change.
- **FLUSH:**
  - `a_ready`=0, `w_ready`=0, `busy`=1.
  - Zeros are injected for FLUSH_CYCLES cycles, counted by a down-counter.
  - On expiry, the FSM moves to LOAD_W and `done`=1 for one cycle.
- **Outputs while idle:** `w_valid`/`a_valid` are ignored while the matching ready is low. `activations` stays 0 in LOAD_W once the skew line has drained.
- **Reset:**
  - `load`, `weights`, `activations`, `busy`, `done`, all skew stages and all counters go to 0.
  - `w_ready`=1 and `a_ready`=0 after reset.
  - Reset asserted mid-operation aborts immediately with the same values; partial preloads and batches are discarded.
- **Boundary conditions:**
  - `a_last` on the first vector is legal: one vector, then flush.
  - `a_valid` held high across the STREAM→FLUSH edge: the next vector is not accepted.
  - `w_valid` held high across the LOAD_W→STREAM edge: no extra load occurs.

## Timing
- Weight row accepted at edge k: `load`=1 and `weights`=row in cycle k..k+1.
- The last weight acceptance at edge k gives `a_ready`=1 from edge k onward. The earliest activation transfer is at edge k+1, so `load` has already dropped.
- Activation accepted at edge k: lane i is visible after edge k+i.
- The last vector accepted at edge k puts the FSM in FLUSH after edge k. `done` pulses after edge k+FLUSH_CYCLES, at the same time `busy` falls.
- Throughput: one weight row or one activation vector per cycle with no bubbles.

## Test plan
- **Reset:** assert `reset`=0 mid-cycle → all outputs 0 asynchronously; `w_ready`=1, `a_ready`=0.
- **Back-to-back weights:** rows {4,3} then {2,1} (lane1,lane0) → `load`=1 for two cycles with `weights`=0x43 then 0x21; then `load`=0 and `a_ready`=1.
- **Skewed batch:** vectors {2,1} then {4,3} with `a_last` on the second → `activations` = 0x01, 0x23, 0x40, then 0x00. `done` pulses 4 cycles after the last transfer; `busy` is high throughout.
- **Bubble:** `a_valid` low for one cycle between {2,1} and {4,3} → `activations` = 0x01, 0x20, 0x03, 0x40.
- **Gappy weights:** `w_valid` toggling 1,0,1 → `load` high only in the two cycles after transfers; `weights` holds 0x43 during the gap.
- **Reset mid-STREAM:** reset asserted after the first vector → `activations`=0 and `busy`=0 immediately. After release the FSM is in LOAD_W and requires two new weight rows.
